// File: rtl/huffman_param_if.sv
`timescale 1ns/1ps
// huffman_param_if
// Bundles the sample stream and the published results of huffman_param.
//
// Handshake: a sample (gray_data) is taken on a rising clk edge where both
// gray_valid and gray_ready are high. A sample offered while gray_ready is
// low is dropped, not held. The producer never waits on gray_ready.
// CNT_valid and code_valid are one-cycle pulses with no back-pressure. CNT,
// HC and M keep their value until the next pulse of their strobe.
//
// Signals:
//   gray_valid  producer -> core  sample strobe
//   gray_data   producer -> core  sample value, DW bits
//   gray_ready  core -> producer  high while samples are accepted
//   CNT_valid   core -> consumer  pulse, new CNT published
//   CNT         core -> consumer  per-symbol counts, symbol s at [(s-1)*CW +: CW]
//   code_valid  core -> consumer  pulse, new HC/M published
//   HC          core -> consumer  per-symbol codes, right-aligned
//   M           core -> consumer  per-symbol masks, (1<<len)-1
interface huffman_param_if #(
    parameter int NSYM   = 6,
    parameter int DW     = 8,
    parameter int CW     = 8,
    parameter int CODE_W = 8
);
    logic                   gray_valid;
    logic [DW-1:0]          gray_data;
    logic                   gray_ready;
    logic                   CNT_valid;
    logic [NSYM*CW-1:0]     CNT;
    logic                   code_valid;
    logic [NSYM*CODE_W-1:0] HC;
    logic [NSYM*CODE_W-1:0] M;

    modport master (
        output gray_valid, gray_data,
        input  gray_ready, CNT_valid, CNT, code_valid, HC, M
    );

    modport slave (
        input  gray_valid, gray_data,
        output gray_ready, CNT_valid, CNT, code_valid, HC, M
    );
endinterface

// File: rtl/huffman_param.sv
`timescale 1ns/1ps
// huffman_param
// Histogram of a frame of TOTAL in-range samples (values 1..NSYM). The core
// publishes the counts and then builds a Huffman tree with one merge per
// cycle. It then publishes per-symbol codes and masks and re-arms for the
// next frame without a reset.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous, active-high; clears all state and outputs
//   bus      huffman_param_if.slave (sample stream and results)
//   o_state  current FSM state (0 COUNT, 1 CNT_OUT, 2 MERGE)
module huffman_param #(
    parameter int NSYM   = 6,
    parameter int DW     = 8,
    parameter int CW     = 8,
    parameter int TOTAL  = 100,
    parameter int CODE_W = 8
) (
    input  logic           clk,
    input  logic           reset,
    huffman_param_if.slave bus,
    output logic [1:0]     o_state
);
    localparam int            GW       = $clog2(NSYM);      // node index width
    localparam int            LW       = $clog2(NSYM + 1);  // code length, up to NSYM-1
    localparam logic [CW-1:0] LAST_IDX = CW'(TOTAL - 1);

    typedef enum logic [1:0] {
        S_COUNT   = 2'd0,
        S_CNT_OUT = 2'd1,
        S_MERGE   = 2'd2
    } state_t;

    state_t                 r_state;
    logic                   r_ready;
    logic                   r_cnt_valid;
    logic                   r_code_valid;
    logic [NSYM*CW-1:0]     r_cnt;
    logic [NSYM*CODE_W-1:0] r_hc;
    logic [NSYM*CODE_W-1:0] r_m;

    logic [CW-1:0]          r_count  [NSYM];
    logic [CW-1:0]          r_total;
    logic [CW-1:0]          r_weight [NSYM];
    logic [NSYM-1:0]        r_active;
    logic [GW-1:0]          r_group  [NSYM];  // tree node each symbol currently belongs to
    logic [CODE_W-1:0]      r_code   [NSYM];
    logic [LW-1:0]          r_len    [NSYM];

    // Sample intake
    logic [NSYM-1:0]        w_hit;
    logic                   w_accept;
    logic                   w_last;
    logic [CW-1:0]          w_count_inc [NSYM];
    logic [NSYM*CW-1:0]     w_cnt_pack;

    // Merge selection
    logic [GW-1:0]          w_min1;
    logic [GW-1:0]          w_min2;
    logic                   w_found1;
    logic                   w_found2;
    logic [LW-1:0]          w_nact;
    logic                   w_merge;
    logic                   w_done;
    logic [CODE_W-1:0]      w_code_nxt [NSYM];
    logic [LW-1:0]          w_len_nxt  [NSYM];
    logic [NSYM*CODE_W-1:0] w_hc_nxt;
    logic [NSYM*CODE_W-1:0] w_m_nxt;

    assign bus.gray_ready = r_ready;
    assign bus.CNT_valid  = r_cnt_valid;
    assign bus.CNT        = r_cnt;
    assign bus.code_valid = r_code_valid;
    assign bus.HC         = r_hc;
    assign bus.M          = r_m;
    assign o_state        = r_state;

    // r_ready is only ever high in COUNT, so a hit implies COUNT.
    // Out-of-range values match no symbol and are ignored.
    always_comb begin
        w_hit      = '0;
        w_cnt_pack = '0;
        for (int s = 0; s < NSYM; s++) begin
            w_hit[s]       = r_ready && bus.gray_valid && (bus.gray_data == DW'(s + 1));
            w_count_inc[s] = r_count[s] + {{(CW-1){1'b0}}, w_hit[s]};
            w_cnt_pack[s*CW +: CW] = w_count_inc[s];
        end
        w_accept = |w_hit;
        w_last   = w_accept && (r_total == LAST_IDX);
    end

    // Smallest two active nodes. The scan runs from the highest index down
    // and replaces only on a strictly smaller weight, so on equal weight the
    // higher index ranks smaller.
    always_comb begin
        w_min1   = '0;
        w_min2   = '0;
        w_found1 = 1'b0;
        w_found2 = 1'b0;
        w_nact   = '0;
        for (int i = NSYM - 1; i >= 0; i--) begin
            if (r_active[i]) begin
                w_nact = w_nact + LW'(1);
                if (!w_found1 || (r_weight[i] < r_weight[w_min1])) begin
                    w_min1   = GW'(i);
                    w_found1 = 1'b1;
                end
            end
        end
        for (int i = NSYM - 1; i >= 0; i--) begin
            if (r_active[i] && (GW'(i) != w_min1)) begin
                if (!w_found2 || (r_weight[i] < r_weight[w_min2])) begin
                    w_min2   = GW'(i);
                    w_found2 = 1'b1;
                end
            end
        end
        w_merge = (w_nact >= LW'(2));
        // Two active on entry means this merge leaves the root; fewer means nothing to merge.
        w_done  = (w_nact <= LW'(2));
    end

    // Codes grow from the leaf upward: each merge writes one bit at the
    // symbol's current length, so the root bit ends at the MSB of the code.
    always_comb begin
        for (int s = 0; s < NSYM; s++) begin
            w_code_nxt[s] = r_code[s];
            w_len_nxt[s]  = r_len[s];
            if (w_merge && (r_group[s] == w_min1)) begin
                w_code_nxt[s][r_len[s]] = 1'b1;
                w_len_nxt[s]            = r_len[s] + LW'(1);
            end else if (w_merge && (r_group[s] == w_min2)) begin
                w_code_nxt[s][r_len[s]] = 1'b0;
                w_len_nxt[s]            = r_len[s] + LW'(1);
            end
        end
    end

    // Published code/mask. A lone symbol has length 0 but still gets mask 1.
    always_comb begin
        w_hc_nxt = '0;
        w_m_nxt  = '0;
        for (int s = 0; s < NSYM; s++) begin
            if (r_count[s] != '0) begin
                w_hc_nxt[s*CODE_W +: CODE_W] = w_code_nxt[s];
                if (w_len_nxt[s] == '0) begin
                    w_m_nxt[s*CODE_W] = 1'b1;
                end else begin
                    for (int b = 0; b < CODE_W; b++) begin
                        w_m_nxt[s*CODE_W + b] = (int'(w_len_nxt[s]) > b);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_COUNT;
            r_ready      <= 1'b0;
            r_cnt_valid  <= 1'b0;
            r_code_valid <= 1'b0;
            r_cnt        <= '0;
            r_hc         <= '0;
            r_m          <= '0;
            r_total      <= '0;
            r_active     <= '0;
            for (int s = 0; s < NSYM; s++) begin
                r_count[s]  <= '0;
                r_weight[s] <= '0;
                r_group[s]  <= '0;
                r_code[s]   <= '0;
                r_len[s]    <= '0;
            end
        end else begin
            r_cnt_valid  <= 1'b0;
            r_code_valid <= 1'b0;
            case (r_state)
                S_COUNT: begin
                    // Ready rises on the first edge after reset.
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        for (int s = 0; s < NSYM; s++) begin
                            r_count[s] <= w_count_inc[s];
                        end
                        r_total <= r_total + CW'(1);
                        if (w_last) begin
                            r_cnt       <= w_cnt_pack;
                            r_cnt_valid <= 1'b1;
                            r_ready     <= 1'b0;
                            r_state     <= S_CNT_OUT;
                        end
                    end
                end

                S_CNT_OUT: begin
                    for (int s = 0; s < NSYM; s++) begin
                        r_weight[s] <= r_count[s];
                        r_active[s] <= (r_count[s] != '0);
                        r_group[s]  <= GW'(s);
                        r_code[s]   <= '0;
                        r_len[s]    <= '0;
                    end
                    r_state <= S_MERGE;
                end

                S_MERGE: begin
                    for (int s = 0; s < NSYM; s++) begin
                        r_code[s] <= w_code_nxt[s];
                        r_len[s]  <= w_len_nxt[s];
                    end
                    if (w_merge) begin
                        r_weight[w_min2] <= r_weight[w_min1] + r_weight[w_min2];
                        r_active[w_min1] <= 1'b0;
                        for (int s = 0; s < NSYM; s++) begin
                            if (r_group[s] == w_min1) begin
                                r_group[s] <= w_min2;
                            end
                        end
                    end
                    if (w_done) begin
                        r_hc         <= w_hc_nxt;
                        r_m          <= w_m_nxt;
                        r_code_valid <= 1'b1;
                        r_ready      <= 1'b1;
                        r_total      <= '0;
                        for (int s = 0; s < NSYM; s++) begin
                            r_count[s] <= '0;
                        end
                        r_state <= S_COUNT;
                    end
                end

                default: begin
                    r_ready <= 1'b0;
                    r_state <= S_COUNT;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_huffman_param.sv
`timescale 1ns/1ps
// tb_huffman_param
// Directed frames against a default instance (NSYM=6, TOTAL=100) and a small
// instance (NSYM=4, TOTAL=8). Expected counts, codes, masks and latencies
// are worked out by hand and queued before each frame.
module tb_huffman_param;
    localparam int W6 = 48;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    huffman_param_if #(.NSYM(6), .DW(8), .CW(8), .CODE_W(8)) b6 ();
    huffman_param_if #(.NSYM(4), .DW(8), .CW(8), .CODE_W(8)) b4 ();
    logic [1:0] st6;
    logic [1:0] st4;

    huffman_param #(.NSYM(6), .DW(8), .CW(8), .TOTAL(100), .CODE_W(8)) u_dut6 (
        .clk(clk), .reset(reset), .bus(b6), .o_state(st6)
    );
    huffman_param #(.NSYM(4), .DW(8), .CW(8), .TOTAL(8), .CODE_W(8)) u_dut4 (
        .clk(clk), .reset(reset), .bus(b4), .o_state(st4)
    );

    // ---------------- scoreboard ----------------
    int             n_cmp = 0;
    int             n_err = 0;
    int             early = 0;
    logic [W6-1:0]  exp_q[$];
    logic [7:0]     stim_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] pk6(input int a, input int b, input int c,
                                        input int d, input int e, input int f);
        return {8'(f), 8'(e), 8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    // ---------------- driver tasks ----------------
    // Counts 20,18,22,10,15,15 for symbols 1..6, optionally shuffled.
    task automatic build_t1(input bit shuf);
        int         cnts[6] = '{20, 18, 22, 10, 15, 15};
        logic [7:0] tmp;
        int         j;
        stim_q.delete();
        for (int s = 0; s < 6; s++)
            for (int n = 0; n < cnts[s]; n++)
                stim_q.push_back(8'(s + 1));
        if (shuf) begin
            for (int i = stim_q.size() - 1; i > 0; i--) begin
                j         = $urandom_range(i, 0);
                tmp       = stim_q[i];
                stim_q[i] = stim_q[j];
                stim_q[j] = tmp;
            end
        end
    endtask

    task automatic push_exp(input logic [W6-1:0] c, input logic [W6-1:0] h, input logic [W6-1:0] m);
        exp_q.push_back(c);
        exp_q.push_back(h);
        exp_q.push_back(m);
    endtask

    // Present every queued sample. A sample is consumed when driven in a
    // cycle where gray_ready is high; the final one is taken on the next edge.
    task automatic feed6(input bit gaps);
        int guard = 0;
        while (stim_q.size() > 0 && guard < 3000) begin
            @(negedge clk);
            guard++;
            if (b6.CNT_valid) early++;
            if (gaps && $urandom_range(0, 3) == 0) begin
                b6.gray_valid = 1'b0;
            end else begin
                b6.gray_valid = 1'b1;
                b6.gray_data  = stim_q[0];
                if (b6.gray_ready) void'(stim_q.pop_front());
            end
        end
        if (stim_q.size() > 0) begin
            chk("feed_timeout", 64'(stim_q.size()), 64'd0);
            stim_q.delete();
        end
    endtask

    // Check the CNT pulse (cycle c) and the code pulse lat cycles later.
    // Junk value 2 is offered throughout the busy window and must be dropped.
    task automatic finish6(input string tag, input int lat, input bit carry_en, input logic [7:0] carry_val);
        logic [W6-1:0] e_cnt, e_hc, e_m;
        int            k;
        int            busy_hi;
        bit            got;
        e_cnt = exp_q.pop_front();
        e_hc  = exp_q.pop_front();
        e_m   = exp_q.pop_front();
        @(negedge clk);
        b6.gray_valid = 1'b1;
        b6.gray_data  = 8'd2;
        chk({tag, "_early_cnt_valid"}, 64'(early), 64'd0);
        early = 0;
        chk({tag, "_cnt_valid"}, 64'(b6.CNT_valid), 64'd1);
        chk({tag, "_cnt"}, 64'(b6.CNT), 64'(e_cnt));
        chk({tag, "_ready_low_c"}, 64'(b6.gray_ready), 64'd0);
        k       = 0;
        busy_hi = 0;
        got     = 1'b0;
        while (!got && k < 20) begin
            @(negedge clk);
            k++;
            if (b6.code_valid) got = 1'b1;
            else if (b6.gray_ready) busy_hi++;
        end
        chk({tag, "_code_latency"}, 64'(k), 64'(lat));
        chk({tag, "_hc"}, 64'(b6.HC), 64'(e_hc));
        chk({tag, "_m"}, 64'(b6.M), 64'(e_m));
        chk({tag, "_ready_busy"}, 64'(busy_hi), 64'd0);
        chk({tag, "_ready_at_code"}, 64'(b6.gray_ready), 64'd1);
        chk({tag, "_cnt_held"}, 64'(b6.CNT), 64'(e_cnt));
        if (carry_en) begin
            b6.gray_data  = carry_val;
            b6.gray_valid = 1'b1;
            @(negedge clk);
            b6.gray_valid = 1'b0;
            chk({tag, "_code_pulse"}, 64'(b6.code_valid), 64'd0);
        end else begin
            b6.gray_valid = 1'b0;
        end
    endtask

    task automatic run4();
        logic [7:0] s4[$];
        int         guard = 0;
        int         k;
        bit         got;
        s4 = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd4, 8'd3, 8'd2, 8'd1};
        while (s4.size() > 0 && guard < 200) begin
            @(negedge clk);
            guard++;
            b4.gray_valid = 1'b1;
            b4.gray_data  = s4[0];
            if (b4.gray_ready) void'(s4.pop_front());
        end
        @(negedge clk);
        b4.gray_valid = 1'b0;
        chk("n4_cnt_valid", 64'(b4.CNT_valid), 64'd1);
        chk("n4_cnt", 64'(b4.CNT), 64'h0202_0202);
        k   = 0;
        got = 1'b0;
        while (!got && k < 20) begin
            @(negedge clk);
            k++;
            if (b4.code_valid) got = 1'b1;
        end
        chk("n4_code_latency", 64'(k), 64'd4);
        chk("n4_hc", 64'(b4.HC), 64'h0302_0100);
        chk("n4_m", 64'(b4.M), 64'h0303_0303);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] junk[3];
        logic [7:0] tmpq[$];
        junk = '{8'd0, 8'd7, 8'd255};
        b6.gray_valid = 1'b0;
        b6.gray_data  = '0;
        b4.gray_valid = 1'b0;
        b4.gray_data  = '0;

        // Reset state
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(b6.gray_ready), 64'd0);
        chk("rst_cnt_valid", 64'(b6.CNT_valid), 64'd0);
        chk("rst_code_valid", 64'(b6.code_valid), 64'd0);
        chk("rst_cnt", 64'(b6.CNT), 64'd0);
        chk("rst_hc", 64'(b6.HC), 64'd0);
        chk("rst_m", 64'(b6.M), 64'd0);
        chk("rst_state", 64'(st6), 64'd0);
        chk("rst_state4", 64'(st4), 64'd0);
        reset = 1'b0;

        // Full alphabet, shuffled with gaps; a sample in the code cycle opens the next frame
        build_t1(1'b1);
        push_exp(pk6(20, 18, 22, 10, 15, 15), pk6(3, 0, 2, 3, 1, 2), pk6(3, 7, 3, 7, 7, 7));
        feed6(1'b1);
        finish6("t1", 6, 1'b1, 8'd6);

        // Second frame: counts restart, carry sample counted, outputs hold mid-frame
        stim_q.delete();
        for (int i = 0; i < 50; i++) stim_q.push_back(8'd6);
        feed6(1'b1);
        @(negedge clk);
        b6.gray_valid = 1'b0;
        chk("hold_cnt", 64'(b6.CNT), 64'(pk6(20, 18, 22, 10, 15, 15)));
        chk("hold_hc", 64'(b6.HC), 64'(pk6(3, 0, 2, 3, 1, 2)));
        chk("hold_m", 64'(b6.M), 64'(pk6(3, 7, 3, 7, 7, 7)));
        chk("hold_code_valid", 64'(b6.code_valid), 64'd0);
        for (int i = 0; i < 49; i++) stim_q.push_back(8'd6);
        push_exp(pk6(0, 0, 0, 0, 0, 100), pk6(0, 0, 0, 0, 0, 0), pk6(0, 0, 0, 0, 0, 1));
        feed6(1'b1);
        finish6("t5b", 2, 1'b0, 8'd0);

        // Single symbol
        stim_q.delete();
        for (int i = 0; i < 100; i++) stim_q.push_back(8'd3);
        push_exp(pk6(0, 0, 100, 0, 0, 0), pk6(0, 0, 0, 0, 0, 0), pk6(0, 0, 1, 0, 0, 0));
        feed6(1'b0);
        finish6("t2", 2, 1'b0, 8'd0);

        // Out-of-range values interleaved; last presented sample is in range
        build_t1(1'b0);
        tmpq.delete();
        for (int i = 0; i < 100; i++) begin
            if (i % 9 == 4) tmpq.push_back(junk[(i / 9) % 3]);
            tmpq.push_back(stim_q[i]);
        end
        stim_q = tmpq;
        push_exp(pk6(20, 18, 22, 10, 15, 15), pk6(3, 0, 2, 3, 1, 2), pk6(3, 7, 3, 7, 7, 7));
        feed6(1'b0);
        finish6("t3", 6, 1'b0, 8'd0);

        // NSYM=4, all ties
        run4();

        // Reset during MERGE
        build_t1(1'b1);
        feed6(1'b1);
        @(negedge clk);
        b6.gray_valid = 1'b0;
        chk("t6_cnt_valid", 64'(b6.CNT_valid), 64'd1);
        early = 0;
        @(negedge clk);
        @(negedge clk);
        chk("t6_state_merge", 64'(st6), 64'd2);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_ready", 64'(b6.gray_ready), 64'd0);
        chk("t6_rst_cnt", 64'(b6.CNT), 64'd0);
        chk("t6_rst_hc", 64'(b6.HC), 64'd0);
        chk("t6_rst_m", 64'(b6.M), 64'd0);
        chk("t6_rst_cnt_valid", 64'(b6.CNT_valid), 64'd0);
        chk("t6_rst_code_valid", 64'(b6.code_valid), 64'd0);
        chk("t6_rst_state", 64'(st6), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        build_t1(1'b1);
        push_exp(pk6(20, 18, 22, 10, 15, 15), pk6(3, 0, 2, 3, 1, 2), pk6(3, 7, 3, 7, 7, 7));
        feed6(1'b1);
        finish6("t6b", 6, 1'b0, 8'd0);

        // Final report
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/huffman_param.md
# huffman_param

Parametrised histogram and Huffman code generator for NSYM gray-level symbols. It accepts a frame of TOTAL in-range samples and publishes the per-symbol counts. It then builds a Huffman tree with one merge per cycle and publishes per-symbol codes and masks. It then clears itself and accepts the next frame without a reset.

## Interface
- NSYM, 6, number of symbols; symbol values 1..NSYM (NSYM ≥ 2, NSYM−1 ≤ CODE_W)
- DW, 8, gray_data width
- CW, 8, count width (TOTAL < 2^CW)
- TOTAL, 100, in-range samples per frame
- CODE_W, 8, code/mask width per symbol
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- gray_valid  in  1  sample strobe
- gray_data  in  DW  sample value
- gray_ready  out  1  high while samples are accepted (COUNT state)
- CNT_valid  out  1  one-cycle pulse; CNT valid from this cycle until next pulse
- CNT  out  NSYM*CW  count of symbol s at [(s−1)*CW +: CW]
- code_valid  out  1  one-cycle pulse; HC/M valid from this cycle until next pulse
- HC  out  NSYM*CODE_W  code of symbol s, right-aligned, root bit at MSB of its length
- M  out  NSYM*CODE_W  mask of symbol s: (1<<len)−1

## Operation
- States: COUNT, CNT_OUT, MERGE. Reset → COUNT; all outputs 0; internal counters, weights, codes and lengths 0.
- COUNT: gray_ready=1. On gray_valid with 1 ≤ gray_data ≤ NSYM, increment the internal count of that symbol and the sample counter. Other values are ignored and do not count toward TOTAL.
- On the edge accepting the TOTAL-th sample: load CNT with the final counts including that sample, set CNT_valid←1, go to CNT_OUT.
- CNT_OUT (1 cycle): gray_ready=0, CNT_valid=1. Load node weight[s]=count[s]. Node s is active iff count[s]≠0. Clear code[s] and len[s]. Go to MERGE.
- MERGE: gray_ready=0. Samples presented while gray_ready=0 are dropped.
  - Node ordering ascending by weight. On equal weight, the higher node index ranks smaller.
  - If ≥2 nodes are active, merge per cycle. min1 is the smallest, min2 the next.
  - Every symbol whose group is min1 gets bit 1 written at position len[s], then len[s]++. Every symbol in min2 gets bit 0 the same way.
  - weight[min2]←weight[min1]+weight[min2]. min1 is deactivated and its symbols regrouped to min2.
  - When the cycle's result leaves ≤1 active node, or <2 were active on entry, register outputs and set code_valid←1:
    - HC(s) = code[s] for symbols with nonzero count.
    - M(s) = (1<<len[s])−1 for those symbols.
    - A lone nonzero symbol (len 0) outputs HC=0, M=1.
    - Zero-count symbols output HC=0, M=0.
  - On that same edge go to COUNT and clear the internal counts and sample counter.
- Widths: weights ≤ TOTAL fit in CW, with no overflow handling. len never exceeds NSYM−1.

## Timing
- CNT_valid is high in cycle c, the cycle after the edge that accepted the TOTAL-th sample.
- With m = (nonzero symbols − 1), merges occur in cycles c+1..c+m. code_valid is high in cycle c+1+max(m,1). Default NSYM=6 with all symbols present gives c+6.
- gray_ready is low from cycle c through the cycle before code_valid. It is high in the code_valid cycle, and a sample there counts toward the next frame.
- CNT, HC and M hold between pulses. CNT updates one frame ahead of HC/M.
- Async reset at any point, including mid-MERGE, forces all outputs to 0 immediately and restarts in COUNT. A partial frame is discarded.

## Test plan
- Default params; counts 20,18,22,10,15,15 for symbols 1..6, in any order, with gray_valid gaps. Required: CNT_valid with those counts. code_valid 6 cycles later with HC=3,0,2,3,1,2 and M=3,7,3,7,7,7.
- 100 samples of value 3. Required: CNT3=100, others 0. code_valid at c+2 with HC3=0, M3=1, all other HC/M 0.
- Interleave values 0, 7 and 255 among 100 valid samples. Required: the ignored values do not advance the count. CNT_valid occurs only after the 100th in-range sample.
- NSYM=4, TOTAL=8, counts 2,2,2,2. Required: HC=0,1,2,3, all M=3, code_valid at c+4.
- Two back-to-back frames. Required: the second frame's counts start from 0. A sample in the code_valid cycle is counted. Samples during CNT_OUT/MERGE are dropped. Outputs hold between pulses.
- Assert reset mid-MERGE, then deassert. Required: all outputs 0 at once, state COUNT, and the next full frame produces correct codes.
